// File: rtl/timer_pkg.sv
// Shared definitions for the bus_timer memory-mapped countdown timer.
// Holds the register offsets selected by ADDR[1:0], the STATUS/CONTROL bit
// positions and the two-state FSM encoding used by the top level.
package timer_pkg;

    // Register offsets (ADDR[1:0])
    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_CONTROL = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_COUNT   = 2'd3;

    // STATUS bit positions
    localparam int STAT_TO  = 0;
    localparam int STAT_RUN = 1;

    // CONTROL bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;
    localparam int CTRL_CONT  = 2;
    localparam int CTRL_ITO   = 3;

    typedef enum logic {
        T_IDLE    = 1'b0,
        T_RUNNING = 1'b1
    } state_e;

endpackage

// File: rtl/bus_timer_tick_gen.sv
// tick_gen: prescaler for bus_timer. Counts 0..PRESCALE-1 while en is high
// and raises tick for one cycle when the counter sits on its last value, so the
// consumer sees exactly one tick every PRESCALE clocks after a clear.
// Ports:
//   Clock  - system clock
//   Resetn - asynchronous active-low reset
//   en     - count enable (timer running)
//   clr    - synchronous clear back to 0 (restart)
//   tick   - one-cycle pulse, once per PRESCALE clocks
module tick_gen #(
    parameter int PRESCALE = 50000
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next prescaler value: held at 0 while disabled or cleared, wraps at LAST
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Prescaler counter register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Derived from the registered count, so it is a clean single-cycle pulse
    assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped countdown timer on the processor bus.
// Selected when ADDR[15:12]==BASE; ADDR[1:0] picks STATUS/CONTROL/PERIOD/COUNT.
// Read data is registered (1-clock latency) to match the synchronous inst_mem.
// Optional feature macro: TIMER_IRQ_EN (adds IRQ port and CONTROL.ITO bit).
// Ports:
//   Clock  - system clock
//   Resetn - asynchronous active-low reset
//   ADDR   - processor address
//   DOUT   - processor write data
//   W      - processor write strobe
//   Q      - registered read data
//   IRQ    - registered TO & ITO (only with TIMER_IRQ_EN)
module bus_timer
    import timer_pkg::*;
#(
    parameter logic [3:0] BASE     = 4'h4,
    parameter int         PRESCALE = 50000
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [15:0] ADDR,
    input  logic [15:0] DOUT,
    input  logic        W,
    output logic [15:0] Q
`ifdef TIMER_IRQ_EN
    ,
    output logic        IRQ
`endif
);

    state_e      state_q;
    logic [15:0] count_q;
    logic [15:0] period_q;
    logic        to_q;
    logic        cont_q;
    logic        ito_s;
    logic [15:0] q_q;
    logic [15:0] rdata_d;

    logic        cs_s;
    logic        wr_s;
    logic        rd_s;
    logic [1:0]  sel_s;
    logic        start_s;
    logic        stop_s;
    logic        start_ok_s;
    logic        tick_s;
    logic        timeout_s;
    logic        to_clr_s;
    logic        running_s;
    logic        unused_s;

    assign cs_s      = (ADDR[15:12] == BASE);
    assign wr_s      = cs_s && W;
    assign rd_s      = cs_s && !W;
    assign sel_s     = ADDR[1:0];
    assign running_s = (state_q == T_RUNNING);
    assign unused_s  = ^ADDR[11:2];

    assign start_s    = wr_s && (sel_s == REG_CONTROL) && DOUT[CTRL_START];
    assign stop_s     = wr_s && (sel_s == REG_CONTROL) && DOUT[CTRL_STOP];
    // STOP beats START; START with PERIOD==0 is ignored entirely
    assign start_ok_s = start_s && !stop_s && (period_q != 16'd0);
    assign to_clr_s   = wr_s && (sel_s == REG_STATUS) && DOUT[STAT_TO];
    // Reaching the last count only times out if no STOP/START overrides it
    assign timeout_s  = running_s && tick_s && !stop_s && !start_ok_s && (count_q == 16'd1);

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .Clock (Clock),
        .Resetn(Resetn),
        .en    (running_s),
        .clr   (start_ok_s),
        .tick  (tick_s)
    );

`ifdef TIMER_IRQ_EN
    logic ito_q;
    logic irq_q;

    // IRQ enable bit and registered interrupt output
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ito_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (wr_s && (sel_s == REG_CONTROL)) begin
                ito_q <= DOUT[CTRL_ITO];
            end
            irq_q <= to_q && ito_q;
        end
    end

    assign ito_s = ito_q;
    assign IRQ   = irq_q;
`else
    assign ito_s = 1'b0;
`endif

    // Read mux for the register selected by ADDR[1:0]
    always_comb begin
        rdata_d = 16'h0000;
        case (sel_s)
            REG_STATUS: begin
                rdata_d[STAT_TO]  = to_q;
                rdata_d[STAT_RUN] = running_s;
            end
            REG_CONTROL: begin
                rdata_d[CTRL_CONT] = cont_q;
                rdata_d[CTRL_ITO]  = ito_s;
            end
            REG_PERIOD: rdata_d = period_q;
            REG_COUNT:  rdata_d = count_q;
            default:    rdata_d = 16'h0000;
        endcase
    end

    // Bus-visible configuration registers and registered read data
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            period_q <= 16'h0000;
            cont_q   <= 1'b0;
            q_q      <= 16'h0000;
        end else begin
            if (wr_s && (sel_s == REG_PERIOD)) begin
                period_q <= DOUT;
            end
            if (wr_s && (sel_s == REG_CONTROL)) begin
                cont_q <= DOUT[CTRL_CONT];
            end
            if (rd_s) begin
                q_q <= rdata_d;
            end
        end
    end

    // Timer FSM: state, countdown value and sticky timeout flag
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= T_IDLE;
            count_q <= 16'h0000;
            to_q    <= 1'b0;
        end else begin
            case (state_q)
                T_IDLE: begin
                    if (start_ok_s) begin
                        state_q <= T_RUNNING;
                        count_q <= period_q;
                    end
                end
                T_RUNNING: begin
                    if (stop_s) begin
                        state_q <= T_IDLE;
                    end else if (start_ok_s) begin
                        count_q <= period_q;
                    end else if (timeout_s) begin
                        // Reload uses the PERIOD value in force at this edge
                        if (cont_q && (period_q != 16'd0)) begin
                            count_q <= period_q;
                        end else begin
                            count_q <= 16'h0000;
                            state_q <= T_IDLE;
                        end
                    end else if (tick_s) begin
                        count_q <= count_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= T_IDLE;
                end
            endcase

            // A timeout in the same cycle as a clear keeps TO set
            if (timeout_s) begin
                to_q <= 1'b1;
            end else if (to_clr_s) begin
                to_q <= 1'b0;
            end
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_bus_timer.sv
module tb_bus_timer;

    localparam int PRE = 4;
`ifdef TIMER_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] Q;
`ifdef TIMER_IRQ_EN
    logic        IRQ;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state (elapsed-time view of the timer)
    bit          m_run;
    bit          m_to;
    bit          m_cont;
    bit          m_ito;
    logic [15:0] m_period;
    int          m_cur;     // period loaded at last start/reload
    int          m_cyc;     // clocks since last start/reload
    logic [15:0] m_frozen;  // count shown while not running
    logic [15:0] m_q;
    bit          m_irq;

    bus_timer #(
        .BASE    (4'h4),
        .PRESCALE(PRE)
    ) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .ADDR  (ADDR),
        .DOUT  (DOUT),
        .W     (W),
        .Q     (Q)
`ifdef TIMER_IRQ_EN
        ,
        .IRQ   (IRQ)
`endif
    );

    always #5 Clock = ~Clock;

    function automatic logic [15:0] ra(input int r);
        logic [15:0] a;
        a = 16'h4000;
        a[1:0] = 2'(r);
        return a;
    endfunction

    task automatic model_reset();
        m_run = 0; m_to = 0; m_cont = 0; m_ito = 0; m_period = 16'h0;
        m_cur = 0; m_cyc = 0; m_frozen = 16'h0; m_q = 16'h0; m_irq = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        bit cs, wr, rd, start, stop, timeout;
        int sel;
        logic [15:0] cnt_now, new_q;
        cs = (ADDR[15:12] == 4'h4);
        wr = cs && W;
        rd = cs && !W;
        sel = int'(ADDR[1:0]);
        cnt_now = m_run ? 16'(m_cur - m_cyc / PRE) : m_frozen;
        new_q = m_q;
        if (rd) begin
            case (sel)
                0: new_q = {14'h0, m_run, m_to};
                1: new_q = {12'h0, m_ito, m_cont, 2'b00};
                2: new_q = m_period;
                default: new_q = cnt_now;
            endcase
        end
        start = wr && sel == 1 && DOUT[0];
        stop = wr && sel == 1 && DOUT[1];
        timeout = 0;
        if (stop) begin
            if (m_run) begin
                m_frozen = cnt_now;
                m_run = 0;
            end
        end else if (start && m_period != 16'h0) begin
            m_run = 1; m_cur = int'(m_period); m_cyc = 0;
        end else if (m_run) begin
            m_cyc++;
            if (m_cyc == m_cur * PRE) begin
                timeout = 1;
                if (m_cont && m_period != 16'h0) begin
                    m_cur = int'(m_period); m_cyc = 0;
                end else begin
                    m_run = 0; m_frozen = 16'h0;
                end
            end
        end
        m_irq = m_to && m_ito;
        if (timeout) m_to = 1;
        else if (wr && sel == 0 && DOUT[0]) m_to = 0;
        if (wr && sel == 1) begin
            m_cont = DOUT[2];
            m_ito = IRQ_EN ? DOUT[3] : 1'b0;
        end
        if (wr && sel == 2) m_period = DOUT;
        m_q = new_q;
    endtask

    task automatic step();
        if (Resetn) model_edge();
        else model_reset();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        ADDR = 16'h0000; W = 1'b0;
        repeat (n) step();
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        ADDR = a; DOUT = d; W = 1'b1;
        step();
        ADDR = 16'h0000; DOUT = 16'h0000; W = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] q);
        ADDR = a; W = 1'b0;
        step();
        q = Q;
        ADDR = 16'h0000;
    endtask

    task automatic test_reset();
        logic [15:0] q;
        Resetn = 1'b0; ADDR = 16'h0000; DOUT = 16'h0000; W = 1'b0;
        model_reset();
        #22;
        checks++;
        if (Q !== 16'h0000) begin errors++; $display("FAIL reset_q: got %h expected 0000", Q); end
        Resetn = 1'b1;
        idle(1);
        for (int r = 0; r < 4; r++) begin
            bus_read(ra(r), q);
            checks++;
            if (q !== 16'h0000) begin errors++; $display("FAIL reset_read%0d: got %h expected 0000", r, q); end
        end
    endtask

    task automatic test_oneshot();
        logic [15:0] q;
        logic [15:0] exp [6] = '{16'd3, 16'd2, 16'd1, 16'h0002, 16'h0001, 16'd0};
        bus_write(ra(2), 16'd3);
        bus_write(ra(1), 16'h0001);
        bus_read(ra(3), q);
        checks++; if (q !== exp[0]) begin errors++; $display("FAIL oneshot_cnt3: got %h expected %h", q, exp[0]); end
        idle(3); bus_read(ra(3), q);
        checks++; if (q !== exp[1]) begin errors++; $display("FAIL oneshot_cnt2: got %h expected %h", q, exp[1]); end
        idle(3); bus_read(ra(3), q);
        checks++; if (q !== exp[2]) begin errors++; $display("FAIL oneshot_cnt1: got %h expected %h", q, exp[2]); end
        idle(2); bus_read(ra(0), q);
        checks++; if (q !== exp[3]) begin errors++; $display("FAIL oneshot_pre_to: got %h expected %h", q, exp[3]); end
        bus_read(ra(0), q);
        checks++; if (q !== exp[4]) begin errors++; $display("FAIL oneshot_to: got %h expected %h", q, exp[4]); end
        bus_read(ra(3), q);
        checks++; if (q !== exp[5]) begin errors++; $display("FAIL oneshot_cnt0: got %h expected %h", q, exp[5]); end
    endtask

    task automatic test_cont();
        logic [15:0] q;
        bus_write(ra(0), 16'h0001);
        bus_write(ra(2), 16'd2);
        bus_write(ra(1), 16'h0005);
        idle(7); bus_read(ra(0), q);
        checks++; if (q !== 16'h0002) begin errors++; $display("FAIL cont_pre_to: got %h expected 0002", q); end
        bus_read(ra(0), q);
        checks++; if (q !== 16'h0003) begin errors++; $display("FAIL cont_to: got %h expected 0003", q); end
        bus_read(ra(3), q);
        checks++; if (q !== 16'd2) begin errors++; $display("FAIL cont_reload: got %h expected 0002", q); end
        bus_write(ra(0), 16'h0001);
        bus_read(ra(0), q);
        checks++; if (q !== 16'h0002) begin errors++; $display("FAIL cont_clear: got %h expected 0002", q); end
        idle(3); bus_read(ra(0), q);
        checks++; if (q !== 16'h0002) begin errors++; $display("FAIL cont_pre_to2: got %h expected 0002", q); end
        bus_read(ra(0), q);
        checks++; if (q !== 16'h0003) begin errors++; $display("FAIL cont_to2: got %h expected 0003", q); end
        bus_write(ra(1), 16'h0002);
        bus_write(ra(0), 16'h0001);
    endtask

    task automatic test_zero_period();
        logic [15:0] q;
        bus_write(ra(2), 16'd0);
        bus_write(ra(1), 16'h0001);
        idle(6); bus_read(ra(0), q);
        checks++; if (q !== 16'h0000) begin errors++; $display("FAIL zero_period: got %h expected 0000", q); end
    endtask

    task automatic test_stop();
        logic [15:0] q;
        bus_write(ra(2), 16'd5);
        bus_write(ra(1), 16'h0001);
        bus_read(ra(3), q);
        checks++; if (q !== 16'd5) begin errors++; $display("FAIL stop_cnt5: got %h expected 0005", q); end
        bus_write(ra(1), 16'h0003);
        idle(10); bus_read(ra(0), q);
        checks++; if (q !== 16'h0000) begin errors++; $display("FAIL stop_status: got %h expected 0000", q); end
        bus_read(ra(3), q);
        checks++; if (q !== 16'd5) begin errors++; $display("FAIL stop_hold: got %h expected 0005", q); end
        bus_read(ra(1), q);
        checks++; if (q !== 16'h0000) begin errors++; $display("FAIL stop_ctrl: got %h expected 0000", q); end
    endtask

    task automatic test_irq();
`ifdef TIMER_IRQ_EN
        logic [15:0] q;
        bus_write(ra(0), 16'h0001);
        bus_write(ra(2), 16'd1);
        bus_write(ra(1), 16'h0009);
        idle(4);
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", IRQ); end
        idle(1);
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", IRQ); end
        bus_read(ra(1), q);
        checks++; if (q !== 16'h0008) begin errors++; $display("FAIL irq_ctrl: got %h expected 0008", q); end
        bus_write(ra(0), 16'h0001);
        idle(1);
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", IRQ); end
        bus_write(ra(1), 16'h0000);
`endif
    endtask

    task automatic test_async_reset();
        logic [15:0] q;
        bus_write(ra(2), 16'd1);
        bus_write(ra(1), 16'h0005);
        idle(6); bus_read(ra(0), q);
        checks++; if (q !== 16'h0003) begin errors++; $display("FAIL areset_pre: got %h expected 0003", q); end
        #3;
        Resetn = 1'b0;
        model_reset();
        #1;
        checks++; if (Q !== 16'h0000) begin errors++; $display("FAIL areset_q: got %h expected 0000", Q); end
`ifdef TIMER_IRQ_EN
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL areset_irq: got %b expected 0", IRQ); end
`endif
        @(negedge Clock);
        Resetn = 1'b1;
        bus_read(ra(0), q);
        checks++; if (q !== 16'h0000) begin errors++; $display("FAIL areset_status: got %h expected 0000", q); end
        bus_read(ra(3), q);
        checks++; if (q !== 16'h0000) begin errors++; $display("FAIL areset_count: got %h expected 0000", q); end
    endtask

    task automatic test_random();
        int op;
        logic [15:0] a;
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            a = 16'($urandom);
            DOUT = 16'($urandom);
            W = 1'b0;
            if (op <= 3) begin
                if (a[15:12] == 4'h4) a[15:12] = 4'h5;
                W = 1'($urandom_range(0, 1));
            end else begin
                a[15:12] = 4'h4;
                if (op >= 7) begin
                    W = 1'b1;
                    a[1:0] = (op == 7) ? 2'd2 : (op == 8) ? 2'd1 : 2'd0;
                    if (op == 7) DOUT = 16'($urandom_range(0, 4));
                end
            end
            ADDR = a;
            step();
            checks++;
            if (Q !== m_q) begin errors++; $display("FAIL random_q[%0d]: got %h expected %h", i, Q, m_q); end
`ifdef TIMER_IRQ_EN
            checks++;
            if (IRQ !== m_irq) begin errors++; $display("FAIL random_irq[%0d]: got %b expected %b", i, IRQ, m_irq); end
`endif
        end
        ADDR = 16'h0000; W = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_cont();
        test_zero_period();
        test_stop();
        test_irq();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
